// File: rtl/lab_pkg.sv
// Shared types and default timing constants for the button input path (50 MHz board clock).
package lab_pkg;

    // Per-channel press-tracking state.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_t;

    // Default cycle counts at 50 MHz.
    localparam int unsigned DEBOUNCE_10MS = 500_000;
    localparam int unsigned LONG_1S       = 50_000_000;
    localparam int unsigned REPEAT_200MS  = 10_000_000;

    // Larger of two cycle counts; sizes the shared hold counter.
    function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debounce filter, press/long/repeat/release FSM.
module button_channel
    import lab_pkg::*;
#(
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned LONG_CYCLES     = LONG_1S,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_200MS
) (
    input  logic clockIn,
    input  logic reset,
    input  logic buttonRaw,
    output logic pressed,
    output logic pressPulse,
    output logic releasePulse,
    output logic longPulse,
    output logic repeatPulse
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(max_cycles(LONG_CYCLES, REPEAT_CYCLES));
    localparam logic        RAW_RELEASED = ACTIVE_LOW;

    logic              r_sync1;
    logic              r_sync2;
    logic              w_s;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_stable;
    logic              r_stable_q;
    btn_state_t        r_state;
    btn_state_t        w_state_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_press;
    logic              w_release;
    logic              w_long;
    logic              w_repeat;
    logic              r_pressed;
    logic              r_press;
    logic              r_release;
    logic              r_long;
    logic              r_repeat;

    // Synchronize the raw level; reset parks both flops at the released level.
    always_ff @(posedge clockIn) begin
        if (reset) begin
            r_sync1 <= RAW_RELEASED;
            r_sync2 <= RAW_RELEASED;
        end else begin
            r_sync1 <= buttonRaw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2 ^ RAW_RELEASED;

    // Flip the stable level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clockIn) begin
        if (reset) begin
            r_db_cnt <= '0;
            r_stable <= 1'b0;
        end else if (w_s != r_stable) begin
            if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= w_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    // Retime the stable level so the FSM decision starts from a plain flop.
    always_ff @(posedge clockIn) begin
        if (reset) begin
            r_stable_q <= 1'b0;
        end else begin
            r_stable_q <= r_stable;
        end
    end

    // Next-state and pulse decode; release always overrides long/repeat.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_stable_q) begin
                    w_press     = 1'b1;
                    w_hold_nxt  = '0;
                    w_state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (!r_stable_q) begin
                    w_release   = 1'b1;
                    w_hold_nxt  = '0;
                    w_state_nxt = IDLE;
                end else if (r_hold_cnt == HOLD_W'(LONG_CYCLES - 1)) begin
                    w_long      = 1'b1;
                    w_hold_nxt  = '0;
                    w_state_nxt = HELD;
                end else begin
                    w_hold_nxt  = r_hold_cnt + HOLD_W'(1);
                end
            end
            HELD: begin
                if (!r_stable_q) begin
                    w_release   = 1'b1;
                    w_hold_nxt  = '0;
                    w_state_nxt = IDLE;
                end else if (r_hold_cnt == HOLD_W'(REPEAT_CYCLES - 1)) begin
                    w_repeat    = 1'b1;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt  = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_hold_nxt  = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, hold counter and registered outputs.
    always_ff @(posedge clockIn) begin
        if (reset) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_pressed  <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_pressed  <= (w_state_nxt != IDLE);
            r_press    <= w_press;
            r_release  <= w_release;
            r_long     <= w_long;
            r_repeat   <= w_repeat;
        end
    end

    assign pressed      = r_pressed;
    assign pressPulse   = r_press;
    assign releasePulse = r_release;
    assign longPulse    = r_long;
    assign repeatPulse  = r_repeat;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BUTTONS raw push-buttons into clean level and single-cycle event buses.
module button_conditioner
    import lab_pkg::*;
#(
    parameter int unsigned N_BUTTONS       = 2,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned LONG_CYCLES     = LONG_1S,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_200MS
) (
    input  logic                 clockIn,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] buttonsRaw,
    output logic [N_BUTTONS-1:0] pressed,
    output logic [N_BUTTONS-1:0] pressPulse,
    output logic [N_BUTTONS-1:0] releasePulse,
    output logic [N_BUTTONS-1:0] longPulse,
    output logic [N_BUTTONS-1:0] repeatPulse
);

    // Reject cycle counts too small for the terminal-match counters.
    if ((DEBOUNCE_CYCLES < 2) || (LONG_CYCLES < 2) || (REPEAT_CYCLES < 2)) begin : g_param_check
        $error("button_conditioner: cycle parameters must be >= 2");
    end

    // One independent channel per button.
    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
        button_channel #(
            .ACTIVE_LOW     (ACTIVE_LOW),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_chan (
            .clockIn     (clockIn),
            .reset       (reset),
            .buttonRaw   (buttonsRaw[gi]),
            .pressed     (pressed[gi]),
            .pressPulse  (pressPulse[gi]),
            .releasePulse(releasePulse[gi]),
            .longPulse   (longPulse[gi]),
            .repeatPulse (repeatPulse[gi])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random segments against an event-time model.
module tb_button_conditioner;

    localparam int unsigned NB  = 2;
    localparam int unsigned DB  = 4;
    localparam int unsigned LG  = 20;
    localparam int unsigned RP  = 5;
    localparam int          LAT = DB + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] raw = '1;
    logic [NB-1:0] pressed, press_p, release_p, long_p, repeat_p;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BUTTONS      (NB),
        .ACTIVE_LOW     (1'b1),
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG),
        .REPEAT_CYCLES  (RP)
    ) dut (
        .clockIn     (clk),
        .reset       (rst),
        .buttonsRaw  (raw),
        .pressed     (pressed),
        .pressPulse  (press_p),
        .releasePulse(release_p),
        .longPulse   (long_p),
        .repeatPulse (repeat_p)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: a run of DB equal samples that differ from the debounced level schedules
    // an event LAT cycles after the first sample of the run; events drive the hold timeline.
    logic          m_stable [NB];
    int            m_run    [NB];
    int            pend_t   [NB];
    logic          pend_v   [NB];
    logic          m_held   [NB];
    int            m_p      [NB];
    logic [NB-1:0] e_pr, e_pp, e_rp, e_lp, e_rep;

    int cnt_pp [NB];
    int cnt_rp [NB];
    int cnt_lp [NB];
    int cnt_rep[NB];
    int cnt_pr [NB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [NB-1:0] r_now, input logic rs);
        int   d;
        logic v;
        for (int c = 0; c < NB; c++) begin
            e_pp[c]  = 1'b0;
            e_rp[c]  = 1'b0;
            e_lp[c]  = 1'b0;
            e_rep[c] = 1'b0;
            if (rs) begin
                m_stable[c] = 1'b0;
                m_run[c]    = 0;
                pend_t[c]   = -1;
                m_held[c]   = 1'b0;
                e_pr[c]     = 1'b0;
            end else begin
                if (pend_t[c] == cyc) begin
                    if (pend_v[c]) begin
                        e_pp[c]   = 1'b1;
                        m_held[c] = 1'b1;
                        m_p[c]    = cyc;
                    end else begin
                        e_rp[c]   = 1'b1;
                        m_held[c] = 1'b0;
                    end
                    pend_t[c] = -1;
                end else if (m_held[c]) begin
                    d = cyc - m_p[c];
                    if (d == int'(LG))
                        e_lp[c] = 1'b1;
                    else if (d > int'(LG) && ((d - int'(LG)) % int'(RP)) == 0)
                        e_rep[c] = 1'b1;
                end
                e_pr[c] = m_held[c];
                v = ~r_now[c];
                if (v != m_stable[c]) begin
                    m_run[c]++;
                    if (m_run[c] == int'(DB)) begin
                        m_stable[c] = v;
                        m_run[c]    = 0;
                        pend_t[c]   = cyc - int'(DB) + 1 + LAT;
                        pend_v[c]   = v;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end
    endtask

    // One clock: model the edge, then compare on the following falling edge.
    task automatic tick();
        logic [NB-1:0] r_now;
        logic          rs;
        r_now = raw;
        rs    = rst;
        @(posedge clk);
        cyc++;
        model_edge(r_now, rs);
        @(negedge clk);
        chk("pressed", 32'(pressed), 32'(e_pr));
        chk("pressPulse", 32'(press_p), 32'(e_pp));
        chk("releasePulse", 32'(release_p), 32'(e_rp));
        chk("longPulse", 32'(long_p), 32'(e_lp));
        chk("repeatPulse", 32'(repeat_p), 32'(e_rep));
        for (int c = 0; c < NB; c++) begin
            cnt_pp[c]  += int'(press_p[c]);
            cnt_rp[c]  += int'(release_p[c]);
            cnt_lp[c]  += int'(long_p[c]);
            cnt_rep[c] += int'(repeat_p[c]);
            cnt_pr[c]  += int'(pressed[c]);
        end
    endtask

    task automatic clr_cnt();
        for (int c = 0; c < NB; c++) begin
            cnt_pp[c]  = 0;
            cnt_rp[c]  = 0;
            cnt_lp[c]  = 0;
            cnt_rep[c] = 0;
            cnt_pr[c]  = 0;
        end
    endtask

    // Repeats produced by a steady hold of h raw samples (release wins on a tie).
    function automatic int exp_rep(input int h);
        return (h > int'(LG)) ? (h - 1 - int'(LG)) / int'(RP) : 0;
    endfunction

    initial begin
        for (int c = 0; c < NB; c++) begin
            m_stable[c] = 1'b0;
            m_run[c]    = 0;
            pend_t[c]   = -1;
            pend_v[c]   = 1'b0;
            m_held[c]   = 1'b0;
            m_p[c]      = 0;
        end
        clr_cnt();

        // Reset state.
        @(negedge clk);
        rst = 1'b1;
        raw = '1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();

        // Clean 15-cycle press.
        clr_cnt();
        raw[0] = 1'b0;
        repeat (15) tick();
        raw[0] = 1'b1;
        repeat (12) tick();
        chk("t1_press_cnt", 32'(cnt_pp[0]), 32'd1);
        chk("t1_release_cnt", 32'(cnt_rp[0]), 32'd1);
        chk("t1_pressed_len", 32'(cnt_pr[0]), 32'd15);
        chk("t1_long_cnt", 32'(cnt_lp[0]), 32'd0);

        // 3-cycle glitch.
        clr_cnt();
        raw[0] = 1'b0;
        repeat (3) tick();
        raw[0] = 1'b1;
        repeat (12) tick();
        chk("t2_press_cnt", 32'(cnt_pp[0]), 32'd0);
        chk("t2_pressed_len", 32'(cnt_pr[0]), 32'd0);

        // Bouncing for 12 cycles, then steady press.
        clr_cnt();
        for (int i = 0; i < 6; i++) begin
            raw[0] = ~raw[0];
            repeat (2) tick();
        end
        raw[0] = 1'b0;
        repeat (12) tick();
        chk("t3_press_cnt", 32'(cnt_pp[0]), 32'd1);
        raw[0] = 1'b1;
        repeat (12) tick();

        // Long hold: long pulse then repeats, release stops them.
        clr_cnt();
        raw[0] = 1'b0;
        repeat (62) tick();
        raw[0] = 1'b1;
        repeat (15) tick();
        chk("t4_long_cnt", 32'(cnt_lp[0]), 32'd1);
        chk("t4_repeat_cnt", 32'(cnt_rep[0]), 32'(exp_rep(62)));
        chk("t4_release_cnt", 32'(cnt_rp[0]), 32'd1);

        // Reset while HELD with the button still down.
        clr_cnt();
        raw[0] = 1'b0;
        repeat (35) tick();
        rst = 1'b1;
        tick();
        chk("t5_pressed_in_reset", 32'(pressed), 32'd0);
        rst = 1'b0;
        repeat (15) tick();
        raw[0] = 1'b1;
        repeat (12) tick();
        chk("t5_press_cnt", 32'(cnt_pp[0]), 32'd2);
        chk("t5_release_cnt", 32'(cnt_rp[0]), 32'd1);
        chk("t5_long_cnt", 32'(cnt_lp[0]), 32'd1);

        // Both buttons together; release only bit 1.
        clr_cnt();
        raw = 2'b00;
        repeat (40) tick();
        raw[1] = 1'b1;
        repeat (25) tick();
        raw[0] = 1'b1;
        repeat (12) tick();
        chk("t6_press_cnt0", 32'(cnt_pp[0]), 32'd1);
        chk("t6_press_cnt1", 32'(cnt_pp[1]), 32'd1);
        chk("t6_repeat_cnt0", 32'(cnt_rep[0]), 32'(exp_rep(65)));
        chk("t6_repeat_cnt1", 32'(cnt_rep[1]), 32'(exp_rep(40)));

        // Random segments of steady levels with occasional reset.
        for (int s = 0; s < 30; s++) begin
            raw = NB'($urandom_range(0, (1 << NB) - 1));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 40)) tick();
        end
        raw = '1;
        repeat (15) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
